// File: rtl/forward_scoreboard_if.sv
// Operand-forwarding scoreboard bus: issue, result write-back, operand
// lookups, and the stall/status signals returned to the front end.
interface forward_scoreboard_if #(
   parameter int DW    = 32,
   parameter int RW    = 5,
   parameter int NRD   = 2,
   parameter int DEPTH = 3,
   parameter int CW    = 8
);
   logic                 flush;
   logic                 issue_valid;
   logic                 issue_wen;
   logic [RW-1:0]        issue_dst;
   logic [DEPTH-1:0]     res_valid;
   logic [DEPTH*DW-1:0]  res_data;
   logic [NRD-1:0]       rd_en;
   logic [NRD*RW-1:0]    rd_addr;
   logic [NRD-1:0]       fwd_hit;
   logic [NRD*DW-1:0]    fwd_data;
   logic                 stall;
   logic [CW-1:0]        stall_cnt;
   logic                 state;
   logic                 hang_err;

   // Pipeline front end / execution stages drive the scoreboard.
   modport master (
      output flush, issue_valid, issue_wen, issue_dst, res_valid, res_data,
             rd_en, rd_addr,
      input  fwd_hit, fwd_data, stall, stall_cnt, state, hang_err
   );

   // The scoreboard itself.
   modport slave (
      input  flush, issue_valid, issue_wen, issue_dst, res_valid, res_data,
             rd_en, rd_addr,
      output fwd_hit, fwd_data, stall, stall_cnt, state, hang_err
   );
endinterface

// File: rtl/forward_scoreboard.sv
// Forwarding scoreboard: tracks in-flight producers (slot 0 = EX, higher
// slots older), bypasses their results to operand read ports, requests a
// stall when the youngest matching producer has no data yet, and counts
// stalls with a sticky error for an excessively long hold.
module forward_scoreboard #(
   parameter int DW      = 32,
   parameter int RW      = 5,
   parameter int NRD     = 2,
   parameter int DEPTH   = 3,
   parameter int CW      = 8,
   parameter int MAXHOLD = 16
) (
   input logic                CLK,
   input logic                RST,
   forward_scoreboard_if.slave bus
);

   localparam int HW = $clog2(MAXHOLD + 1);

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      HOLD = 1'b1
   } state_t;

   // Control part of a slot record; the data word is kept separately.
   typedef struct packed {
      logic          valid;
      logic          wen;
      logic [RW-1:0] dst;
      logic          ready;
   } ctrl_t;

   ctrl_t         slot_ctrl [DEPTH];
   ctrl_t         ctrl_nxt  [DEPTH];
   logic [DW-1:0] slot_data [DEPTH];

   logic [DEPTH-1:0] eff_rdy;
   logic [DW-1:0]    eff_data [DEPTH];
   logic [NRD-1:0]   hazard;
   logic [NRD-1:0]   hit;
   logic [NRD*DW-1:0] fwd_data;
   logic             stall;

   state_t           fsm_state;
   state_t           fsm_nxt;
   logic [CW-1:0]    stall_cnt;
   logic [HW-1:0]    hold_cnt;
   logic [HW-1:0]    hold_nxt;
   logic             hang_err;

   // Effective data per slot: a result arriving this cycle beats stored data.
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         eff_rdy[k]  = bus.res_valid[k] | slot_ctrl[k].ready;
         eff_data[k] = bus.res_valid[k] ? bus.res_data[k*DW +: DW] : slot_data[k];
      end
   end

   // Per-port lookup: scan oldest to youngest so the youngest match wins.
   always_comb begin : lookup
      logic          found;
      logic          rdy;
      logic [DW-1:0] data;
      // NOTE: every output of a combinational block gets a default before any
      // conditional assignment; a path that leaves one unassigned infers a latch.
      hazard   = '0;
      hit      = '0;
      fwd_data = '0;
      for (int i = 0; i < NRD; i++) begin
         found = 1'b0;
         rdy   = 1'b0;
         data  = '0;
         for (int k = DEPTH - 1; k >= 0; k--) begin
            if (bus.rd_en[i] && slot_ctrl[k].valid && slot_ctrl[k].wen &&
                slot_ctrl[k].dst == bus.rd_addr[i*RW +: RW] &&
                bus.rd_addr[i*RW +: RW] != '0) begin
               found = 1'b1;
               rdy   = eff_rdy[k];
               data  = eff_data[k];
            end
         end
         hit[i]    = found & rdy;
         hazard[i] = found & ~rdy;
         if (found && rdy) begin
            fwd_data[i*DW +: DW] = data;
         end
      end
   end

   assign stall = (|hazard) & ~bus.flush;

   // Next slot contents: absorb results, shift one stage, refill slot 0.
   always_comb begin
      for (int k = 1; k < DEPTH; k++) begin
         ctrl_nxt[k]       = slot_ctrl[k-1];
         ctrl_nxt[k].ready = slot_ctrl[k-1].ready | bus.res_valid[k-1];
      end
      if (stall) begin
         ctrl_nxt[0] = '0;
      end else begin
         ctrl_nxt[0] = {bus.issue_valid, bus.issue_wen, bus.issue_dst, 1'b0};
      end
   end

   // Slot control register; reset and flush empty the whole pipeline.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (RST || bus.flush) begin
         for (int k = 0; k < DEPTH; k++) begin
            slot_ctrl[k] <= '0;
         end
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            slot_ctrl[k] <= ctrl_nxt[k];
         end
      end
   end

   // Slot data words travel alongside the control bits.
   always_ff @(posedge CLK) begin
      // NOTE: data words are left out of reset on purpose; they are only ever
      // read once the matching ready bit says they were written.
      slot_data[0] <= '0;
      for (int k = 1; k < DEPTH; k++) begin
         slot_data[k] <= bus.res_valid[k-1] ? bus.res_data[(k-1)*DW +: DW]
                                            : slot_data[k-1];
      end
   end

   // RUN/HOLD next-state logic.
   always_comb begin
      fsm_nxt = fsm_state;
      case (fsm_state)
         RUN:     if (stall) fsm_nxt = HOLD;
         HOLD:    if (!stall || bus.flush) fsm_nxt = RUN;
         default: fsm_nxt = RUN;
      endcase
   end

   // RUN/HOLD state register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         fsm_state <= RUN;
      end else begin
         fsm_state <= fsm_nxt;
      end
   end

   // Consecutive-hold count, saturating at the error threshold.
   always_comb begin
      hold_nxt = hold_cnt;
      if (bus.flush || !stall) begin
         hold_nxt = '0;
      end else if (hold_cnt != HW'(MAXHOLD)) begin
         hold_nxt = hold_cnt + 1'b1;
      end
   end

   // Stall statistics and sticky hang error.
   always_ff @(posedge CLK) begin
      if (RST) begin
         stall_cnt <= '0;
         hold_cnt  <= '0;
         hang_err  <= 1'b0;
      end else begin
         if (stall && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
         hold_cnt <= hold_nxt;
         if (hold_nxt == HW'(MAXHOLD)) begin
            hang_err <= 1'b1;
         end
      end
   end

   assign bus.fwd_hit   = hit;
   assign bus.fwd_data  = fwd_data;
   assign bus.stall     = stall;
   assign bus.stall_cnt = stall_cnt;
   assign bus.state     = fsm_state;
   assign bus.hang_err  = hang_err;

endmodule
